// File: rtl/inst_rom_loader.sv
// -----------------------------------------------------------------------------
// inst_rom_loader
//
// Instruction memory for the CPU fetch port. It has two sides:
//   * Fetch side: a combinational read that returns the word addressed by
//     rom_addr in the same cycle. While a load is running the output is
//     forced to zero.
//   * Load side: a byte-serial valid/ready stream. Bytes are packed
//     big-endian into 32-bit words, which are written to sequential word
//     addresses starting at word 0.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous active-low reset
//   rom_chip_enable  fetch enable from the CPU
//   rom_addr         fetch byte address; bits [1:0] and bits above the depth
//                    are ignored
//   rom_data         fetched instruction word
//   load_start       pulse that starts or restarts a load at word 0
//   load_valid       load_byte is valid
//   load_byte        load data byte
//   load_last        the current byte is the final byte of the image
//   load_ready       a byte is accepted this cycle (high in LOAD)
//   loading          high in LOAD; used to hold the CPU in reset
//   load_word_count  words written by the current or most recent load
//   load_error       sticky: partial final word or overflow
// -----------------------------------------------------------------------------
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rom_chip_enable,
  input  logic [31:0]           rom_addr,
  output logic [31:0]           rom_data,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  loading,
  output logic [DEPTH_LOG2:0]   load_word_count,
  output logic                  load_error
);

  localparam int                DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_byte_cnt;
  logic [DEPTH_LOG2:0]   r_word_ptr;
  logic [31:0]           r_shift;
  logic                  r_error;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_overflow;
  logic                  w_word_done;
  logic [31:0]           w_word;
  logic [DEPTH_LOG2-1:0] w_fetch_idx;
  logic                  w_unused_addr;

  // A restart pulse takes priority, so a byte arriving alongside it is dropped.
  assign w_accept    = load_valid && load_ready && !load_start;
  assign w_overflow  = (r_word_ptr == FULL);
  // Byte n of a word lands at bits [31-8n -: 8]; ~cnt*8 == (3-cnt)*8. Bytes
  // not yet received are still zero in r_shift, which gives the zero padding
  // of a short final word.
  assign w_word      = r_shift | ({24'h0, load_byte} << {~r_byte_cnt, 3'b000});
  assign w_word_done = w_accept && !w_overflow &&
                       ((r_byte_cnt == 2'd3) || load_last);

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state/output decode
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of the order of the blocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    loading     = 1'b0;
    case (r_state)
      IDLE: if (load_start) w_state_nxt = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        loading    = 1'b1;
        if (load_start)                 w_state_nxt = LOAD;
        else if (w_accept && load_last) w_state_nxt = DONE;
      end
      DONE: if (load_start) w_state_nxt = LOAD;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load datapath. Every load_start enters LOAD, so the start pulse is where
  // the per-load counters are cleared.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_byte_cnt <= '0;
      r_word_ptr <= '0;
      r_shift    <= '0;
      r_error    <= 1'b0;
    end else if (load_start) begin
      r_byte_cnt <= '0;
      r_word_ptr <= '0;
      r_shift    <= '0;
      r_error    <= 1'b0;
    end else if (w_accept) begin
      if (w_overflow) begin
        r_error <= 1'b1;
      end else if (w_word_done) begin
        r_word_ptr <= r_word_ptr + 1'b1;
        r_byte_cnt <= '0;
        r_shift    <= '0;
        if (r_byte_cnt != 2'd3) r_error <= 1'b1;
      end else begin
        r_shift    <= w_word;
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
    end
  end

  // The pointer stops at FULL because overflowing bytes are never written, so
  // it is also the saturating count of written words.
  assign load_word_count = r_word_ptr;
  assign load_error      = r_error;

  // NOTE: the array has no reset. Its contents must survive a reset that
  // holds the CPU, and a reset would stop it mapping onto distributed RAM.
  always_ff @(posedge clock) begin
    if (w_word_done) r_mem[r_word_ptr[DEPTH_LOG2-1:0]] <= w_word;
  end

  // ---------------------------------------------------------------------------
  // Fetch path: asynchronous read, wraps modulo the depth
  // ---------------------------------------------------------------------------
  assign w_fetch_idx   = rom_addr[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^{rom_addr[31:DEPTH_LOG2+2], rom_addr[1:0]};
  assign rom_data      = (rom_chip_enable && !loading) ? r_mem[w_fetch_idx] : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_loader
//
// Two instances receive identical stimulus: the default 1024-word memory and
// a 4-word memory used to reach overflow. A behavioural model tracks each
// image as plain arrays. A compare process checks every output of both
// instances on each falling edge. Directed scenarios add literal expectations,
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_inst_rom_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rom_chip_enable = 1'b0;
  logic [31:0] rom_addr = '0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_last = 1'b0;

  logic [31:0] d_rom_data [2];
  logic        d_ready    [2];
  logic        d_loading  [2];
  logic        d_err      [2];
  logic [10:0] d_cnt0;
  logic [2:0]  d_cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  inst_rom_loader #(.DEPTH_LOG2(10)) u_dut0 (
    .clock(clock), .reset(reset),
    .rom_chip_enable(rom_chip_enable), .rom_addr(rom_addr), .rom_data(d_rom_data[0]),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(d_ready[0]), .loading(d_loading[0]),
    .load_word_count(d_cnt0), .load_error(d_err[0])
  );

  inst_rom_loader #(.DEPTH_LOG2(2)) u_dut1 (
    .clock(clock), .reset(reset),
    .rom_chip_enable(rom_chip_enable), .rom_addr(rom_addr), .rom_data(d_rom_data[1]),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(d_ready[1]), .loading(d_loading[1]),
    .load_word_count(d_cnt1), .load_error(d_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: image arrays plus the progress of the current load.
  // ---------------------------------------------------------------------------
  int unsigned m_depth [2] = '{1024, 4};
  logic [31:0] m_mem   [2][1024];
  bit          m_known [2][1024];
  bit          m_load  [2];
  int          m_ptr   [2];
  int          m_nb    [2];
  logic [31:0] m_cur   [2];
  bit          m_err   [2];

  task automatic model_step(input int k);
    if (load_start) begin
      m_load[k] = 1; m_ptr[k] = 0; m_nb[k] = 0; m_cur[k] = 0; m_err[k] = 0;
    end else if (m_load[k] && load_valid) begin
      if (m_ptr[k] == int'(m_depth[k])) begin
        m_err[k] = 1;
      end else begin
        m_cur[k][8*(3-m_nb[k]) +: 8] = load_byte;
        m_nb[k]++;
        if (m_nb[k] == 4 || load_last) begin
          if (m_nb[k] != 4) m_err[k] = 1;
          m_mem[k][m_ptr[k]]   = m_cur[k];
          m_known[k][m_ptr[k]] = 1;
          m_ptr[k]++;
          m_nb[k]  = 0;
          m_cur[k] = 0;
        end
      end
      if (load_last) m_load[k] = 0;
    end
  endtask

  always @(posedge clock or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_load[k] = 0; m_ptr[k] = 0; m_nb[k] = 0; m_cur[k] = 0; m_err[k] = 0;
      end else begin
        model_step(k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge, both instances.
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      int          idx;
      logic [31:0] cnt;
      cnt = (k == 0) ? {21'h0, d_cnt0} : {29'h0, d_cnt1};
      idx = (k == 0) ? int'(rom_addr[11:2]) : int'(rom_addr[3:2]);
      check($sformatf("dut%0d loading", k), {31'h0, d_loading[k]}, {31'h0, m_load[k]});
      check($sformatf("dut%0d load_ready", k), {31'h0, d_ready[k]}, {31'h0, m_load[k]});
      check($sformatf("dut%0d load_error", k), {31'h0, d_err[k]}, {31'h0, m_err[k]});
      check($sformatf("dut%0d load_word_count", k), cnt, m_ptr[k]);
      if (!rom_chip_enable || m_load[k])
        check($sformatf("dut%0d rom_data zero", k), d_rom_data[k], 32'h0);
      else if (m_known[k][idx])
        check($sformatf("dut%0d rom_data", k), d_rom_data[k], m_mem[k][idx]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change just after the falling edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input bit st, input bit v, input logic [7:0] b, input bit l);
    @(negedge clock); #1;
    load_start = st; load_valid = v; load_byte = b; load_last = l;
  endtask

  task automatic idle();
    cyc(0, 0, 8'h00, 0);
  endtask

  task automatic fetch(input logic [31:0] a);
    rom_chip_enable = 1'b1;
    rom_addr = a;
    #1;
  endtask

  task automatic send(input logic [7:0] bytes [], input bit gaps);
    foreach (bytes[i]) begin
      cyc(0, 1, bytes[i], i == bytes.size() - 1);
      if (gaps) cyc(0, 0, 8'hEE, 0);
    end
  endtask

  initial begin
    logic [7:0] b [];

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("reset loading", {31'h0, d_loading[0]}, 32'h0);
    check("reset load_ready", {31'h0, d_ready[0]}, 32'h0);
    check("reset count", {21'h0, d_cnt0}, 32'h0);
    check("reset error", {31'h0, d_err[0]}, 32'h0);
    reset = 1'b1;

    // T1: single word
    cyc(1, 0, 8'h00, 0);
    b = '{8'h3C, 8'h01, 8'h12, 8'h34};
    send(b, 0);
    idle(); fetch(32'h0);
    check("t1 rom_data", d_rom_data[0], 32'h3C011234);
    check("t1 rom_data dut1", d_rom_data[1], 32'h3C011234);
    check("t1 count", {21'h0, d_cnt0}, 32'd1);
    check("t1 error", {31'h0, d_err[0]}, 32'h0);
    check("t1 model mem0", m_mem[0][0], 32'h3C011234);

    // T2: eight bytes, valid toggling
    cyc(1, 0, 8'h00, 0);
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send(b, 1);
    idle(); fetch(32'h4);
    check("t2 word1", d_rom_data[0], 32'h05060708);
    check("t2 count", {21'h0, d_cnt0}, 32'd2);
    fetch(32'h0);
    check("t2 word0", d_rom_data[0], 32'h01020304);

    // T3: partial final word
    cyc(1, 0, 8'h00, 0);
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send(b, 0);
    idle(); fetch(32'h4);
    check("t3 padded word", d_rom_data[0], 32'h11220000);
    check("t3 error", {31'h0, d_err[0]}, 32'h1);
    check("t3 count", {21'h0, d_cnt0}, 32'd2);
    check("t3 model mem1", m_mem[0][1], 32'h11220000);

    // T4: 20 bytes; overflows the 4-word instance
    cyc(1, 0, 8'h00, 0);
    b = new[20];
    foreach (b[i]) b[i] = 8'h40 + 8'(i);
    send(b, 0);
    idle(); fetch(32'h0);
    check("t4 dut1 count", {29'h0, d_cnt1}, 32'd4);
    check("t4 dut1 error", {31'h0, d_err[1]}, 32'h1);
    check("t4 dut1 word0", d_rom_data[1], 32'h40414243);
    check("t4 dut0 count", {21'h0, d_cnt0}, 32'd5);
    check("t4 dut0 error", {31'h0, d_err[0]}, 32'h0);
    fetch(32'h10);
    check("t4 dut1 wrap", d_rom_data[1], 32'h40414243);
    check("t4 dut0 word4", d_rom_data[0], 32'h50515253);

    // T6: fetch blanked in LOAD; restart drops a simultaneous byte
    cyc(1, 0, 8'h00, 0);
    idle(); fetch(32'h0);
    check("t6 loading", {31'h0, d_loading[0]}, 32'h1);
    check("t6 blank", d_rom_data[0], 32'h0);
    cyc(1, 1, 8'h99, 0);
    b = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    send(b, 0);
    idle(); #1;
    check("t6 word0", d_rom_data[0], 32'h5A6B7C8D);
    check("t6 count", {21'h0, d_cnt0}, 32'd1);

    // T5: reset mid-word
    cyc(1, 0, 8'h00, 0);
    b = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hF1, 8'hF2};
    foreach (b[i]) cyc(0, 1, b[i], 0);
    idle();
    #2 reset = 1'b0;
    #1;
    check("t5 ready", {31'h0, d_ready[0]}, 32'h0);
    check("t5 loading", {31'h0, d_loading[0]}, 32'h0);
    check("t5 count", {21'h0, d_cnt0}, 32'h0);
    @(negedge clock); #1 reset = 1'b1;
    idle(); fetch(32'h0);
    check("t5 retained0", d_rom_data[0], 32'hE1E2E3E4);
    fetch(32'h4);
    check("t5 retained1", d_rom_data[0], 32'h44454647);
    check("t5 retained1 dut1", d_rom_data[1], 32'h44454647);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 48) == 0, ($urandom % 3) != 0, 8'($urandom), ($urandom % 30) == 0);
      rom_chip_enable = ($urandom % 4) != 0;
      rom_addr        = $urandom & 32'hFFFF_F03F;
      if (n == 1500) begin
        #2 reset = 1'b0;
        @(negedge clock); #1 reset = 1'b1;
      end
    end
    idle();
    repeat (2) @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
